// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive controller.
// State encoding, parity/bit-index constants and the 2-of-3 vote helper.
package uart_rx_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

  localparam logic       PAR_EVEN      = 1'b0;
  localparam logic       PAR_ODD       = 1'b1;
  localparam logic [3:0] BIT_START     = 4'd0;
  localparam logic [3:0] BIT_LAST_DATA = 4'd8;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Captures RX_IN at edges mid-1, mid and mid+1 of each bit period.
// The majority-voted bit is registered at mid+1 and cleared at the end of the bit.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESC_W = 6
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               RX_IN,
  input  logic [PRESC_W-1:0] prescale,
  input  logic [PRESC_W-1:0] edge_count,
  input  logic               clear,
  output logic               sampled_bit
);

  logic [PRESC_W-1:0] mid;
  logic [1:0]         samp_q;
  logic               bit_q;

  assign mid         = prescale >> 1;
  assign sampled_bit = bit_q;

  // The third sample is folded straight into the vote, so it needs no storage.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      samp_q <= 2'b00;
      bit_q  <= 1'b0;
    end else if (clear) begin
      samp_q <= 2'b00;
      bit_q  <= 1'b0;
    end else begin
      if (edge_count == mid - 1'b1) samp_q[0] <= RX_IN;
      if (edge_count == mid)        samp_q[1] <= RX_IN;
      if (edge_count == mid + 1'b1) bit_q     <= maj3(samp_q[0], samp_q[1], RX_IN);
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start detection, counter enable, LSB-first shift,
// parity and stop checks, registered result pulses. dbg_state mirrors the FSM.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int PRESC_W = 6
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               RX_IN,
  input  logic               PAR_EN,
  input  logic               PAR_TYP,
  input  logic [PRESC_W-1:0] prescale,
  input  logic [3:0]         bit_count,
  input  logic [PRESC_W-1:0] edge_count,
  output logic               cnt_enable,
  output logic [DATA_W-1:0]  P_DATA,
  output logic               data_valid,
  output logic               par_err,
  output logic               stp_err,
  output logic               busy,
  output logic [2:0]         dbg_state
);

  rx_state_t          state_q;
  logic [DATA_W-1:0]  shift_q;
  logic [DATA_W-1:0]  pdata_q;
  logic               par_en_q;
  logic               par_typ_q;
  logic               perr_q;
  logic               dv_q;
  logic               pe_q;
  logic               se_q;
  logic               edge_done;
  logic               sample_clear;
  logic               sampled_bit;

  assign edge_done    = (edge_count == prescale - 1'b1);
  assign sample_clear = edge_done || (state_q == IDLE);

  assign cnt_enable = (state_q != IDLE);
  assign busy       = (state_q != IDLE);
  assign P_DATA     = pdata_q;
  assign data_valid = dv_q;
  assign par_err    = pe_q;
  assign stp_err    = se_q;
  assign dbg_state  = state_q;

  uart_rx_sampler #(
    .PRESC_W (PRESC_W)
  ) u_sampler (
    .CLK         (CLK),
    .RST         (RST),
    .RX_IN       (RX_IN),
    .prescale    (prescale),
    .edge_count  (edge_count),
    .clear       (sample_clear),
    .sampled_bit (sampled_bit)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      pdata_q   <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= PAR_EVEN;
      perr_q    <= 1'b0;
      dv_q      <= 1'b0;
      pe_q      <= 1'b0;
      se_q      <= 1'b0;
    end else begin
      dv_q <= 1'b0;
      pe_q <= 1'b0;
      se_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Frame configuration is frozen here for the whole frame.
          if (!RX_IN) begin
            state_q   <= START;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
            perr_q    <= 1'b0;
          end
        end
        START: begin
          if (edge_done) state_q <= sampled_bit ? IDLE : DATA;
        end
        DATA: begin
          if (edge_done) begin
            shift_q <= {sampled_bit, shift_q[DATA_W-1:1]};
            if (bit_count == BIT_LAST_DATA) state_q <= par_en_q ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (edge_done) begin
            perr_q  <= (((^shift_q) ^ sampled_bit) ? PAR_ODD : PAR_EVEN) != par_typ_q;
            state_q <= STOP;
          end
        end
        STOP: begin
          if (edge_done) begin
            pe_q    <= perr_q;
            se_q    <= ~sampled_bit;
            if (!perr_q && sampled_bit) begin
              dv_q    <= 1'b1;
              pdata_q <= shift_q;
            end
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: models the external bit/edge counter, drives whole
// frames from a vector table and scores every result pulse against a queue.
module tb_uart_rx_ctrl;

  logic       clk;
  logic       rst_n;
  logic       rx_in;
  logic       par_en;
  logic       par_typ;
  logic [5:0] prescale;
  logic [3:0] bit_count;
  logic [5:0] edge_count;
  logic       cnt_enable;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;
  logic       busy;
  logic [2:0] dbg_state;

  int errors = 0;
  int checks = 0;
  logic [10:0] exp_q[$];

  typedef struct {
    int         presc;
    logic       pen;
    logic       ptyp;
    logic [7:0] data;
    logic       pflip;
    logic       sbit;
    logic       noise;
    logic       cfgflip;
    logic       exp_dv;
    logic       exp_pe;
    logic       exp_se;
    logic [7:0] exp_pdata;
  } vec_t;

  vec_t vecs[11];

  uart_rx_ctrl dut (
    .CLK        (clk),
    .RST        (rst_n),
    .RX_IN      (rx_in),
    .PAR_EN     (par_en),
    .PAR_TYP    (par_typ),
    .prescale   (prescale),
    .bit_count  (bit_count),
    .edge_count (edge_count),
    .cnt_enable (cnt_enable),
    .P_DATA     (p_data),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External bit/edge counter: held at zero while disabled.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || !cnt_enable) begin
      bit_count  <= 4'd0;
      edge_count <= 6'd0;
    end else if (edge_count == prescale - 6'd1) begin
      edge_count <= 6'd0;
      bit_count  <= bit_count + 4'd1;
    end else begin
      edge_count <= edge_count + 6'd1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: each result pulse must match the oldest expected record.
  always @(negedge clk) begin
    if (rst_n && (data_valid || par_err || stp_err)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {21'd0, data_valid, par_err, stp_err, p_data}, 32'd0);
      end else begin
        check("result_pulse", {21'd0, data_valid, par_err, stp_err, p_data},
              {21'd0, exp_q.pop_front()});
      end
    end
  end

  // Drives one frame, one RX_IN value per cycle; abort_at > 0 stops early.
  task automatic send_frame(input int presc, input logic pen, input logic ptyp,
                            input logic [7:0] data, input logic pflip, input logic sbit,
                            input logic noise, input logic cfgflip, input int abort_at);
    logic bits [0:10];
    int nb;
    int mid;
    int cyc;
    prescale = presc[5:0];
    par_en   = pen;
    par_typ  = ptyp;
    bits[0]  = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = data[i];
    nb = 9;
    if (pen) begin
      bits[9] = (^data) ^ ptyp ^ pflip;
      nb = 10;
    end
    bits[nb] = sbit;
    nb++;
    mid = presc / 2;
    cyc = 0;
    for (int k = 0; k < nb; k++) begin
      for (int e = 0; e < presc; e++) begin
        if (abort_at > 0 && cyc == abort_at) return;
        rx_in = bits[k];
        if (noise && k >= 1 && k <= 8 && e == mid + 1) rx_in = ~bits[k];
        if (cfgflip && k == 4 && e == 0) begin
          par_en  = ~pen;
          par_typ = ~ptyp;
        end
        @(negedge clk);
        cyc++;
      end
    end
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    check("busy_after_frame", {31'd0, busy}, 32'd0);
    check("cnt_en_after_frame", {31'd0, cnt_enable}, 32'd0);
  endtask

  initial begin
    int n;
    int pidx;
    logic [7:0] rdata;
    logic rpen;
    logic rptyp;
    logic [5:0] presc_tab [0:2];

    presc_tab[0] = 6'd8;
    presc_tab[1] = 6'd16;
    presc_tab[2] = 6'd32;

    //            presc pen   ptyp  data   pflip sbit  noise cfgfl dv    pe    se    pdata
    vecs[0]  = '{8,  1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5};
    vecs[1]  = '{16, 1'b1, 1'b0, 8'h37, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h37};
    vecs[2]  = '{16, 1'b1, 1'b0, 8'h37, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h37};
    vecs[3]  = '{8,  1'b0, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h37};
    vecs[4]  = '{8,  1'b0, 1'b0, 8'h0F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h0F};
    vecs[5]  = '{32, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hC3};
    vecs[6]  = '{8,  1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF};
    vecs[7]  = '{16, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF};
    vecs[8]  = '{32, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF};
    vecs[9]  = '{16, 1'b1, 1'b1, 8'h07, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h07};
    vecs[10] = '{8,  1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h07};

    rst_n    = 1'b0;
    rx_in    = 1'b1;
    par_en   = 1'b0;
    par_typ  = 1'b0;
    prescale = 6'd8;
    repeat (3) @(negedge clk);
    check("rst_cnt_enable", {31'd0, cnt_enable}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_outputs", {29'd0, data_valid, par_err, stp_err}, 32'd0);
    check("rst_p_data", {24'd0, p_data}, 32'd0);
    check("rst_state", {29'd0, dbg_state}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 11; v++) begin
      exp_q.push_back({vecs[v].exp_dv, vecs[v].exp_pe, vecs[v].exp_se, vecs[v].exp_pdata});
      send_frame(vecs[v].presc, vecs[v].pen, vecs[v].ptyp, vecs[v].data, vecs[v].pflip,
                 vecs[v].sbit, vecs[v].noise, vecs[v].cfgflip, 0);
      check("p_data_hold", {24'd0, p_data}, {24'd0, vecs[v].exp_pdata});
    end

    // Start-bit glitch: low for 10 cycles at prescale 32, must drop back silently.
    prescale = 6'd32;
    par_en   = 1'b0;
    rx_in    = 1'b0;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (n == 10) rx_in = 1'b1;
      if (!busy) break;
    end
    check("glitch_idle_cycle", n, 33);
    check("glitch_cnt_enable", {31'd0, cnt_enable}, 32'd0);
    check("glitch_state", {29'd0, dbg_state}, 32'd0);
    repeat (3) @(negedge clk);

    // Reset in the middle of data bit 4 aborts the frame with no pulses.
    send_frame(8, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b0, 1'b0, 5 * 8 + 3);
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", {28'd0, cnt_enable, data_valid, par_err, stp_err}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_p_data", {24'd0, p_data}, 32'd0);
    check("midrst_state", {29'd0, dbg_state}, 32'd0);
    rx_in = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_q.push_back({3'b100, 8'hC3});
    send_frame(8, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b0, 1'b0, 0);

    // Random good frames across legal prescales and parity settings.
    for (int r = 0; r < 6; r++) begin
      pidx  = $urandom_range(0, 2);
      rdata = 8'($urandom_range(0, 255));
      rpen  = 1'($urandom_range(0, 1));
      rptyp = 1'($urandom_range(0, 1));
      exp_q.push_back({3'b100, rdata});
      send_frame(int'(presc_tab[pidx]), rpen, rptyp, rdata, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    end

    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
